// File: rtl/midi_note_stack.sv
// Last-note-priority MIDI voice allocator: keeps a stack of held notes and presents the
// most recently pressed, still-held note with its velocity and a gate.
module midi_note_stack #(
    parameter int DEPTH   = 8,
    parameter int CHANNEL = 0,
    parameter int OMNI    = 0
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         valid_in,
    input  logic [23:0]                  midi_event_in,
    output logic [6:0]                   note_out,
    output logic [6:0]                   velocity_out,
    output logic                         gate_out,
    output logic                         changed_out,
    output logic [$clog2(DEPTH+1)-1:0]   count_out,
    output logic                         busy_out,
    output logic [7:0]                   drop_count_out
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [2:0] {StIdle, StLatch, StMatch, StUpdate, StOutput} state_t;
    typedef enum logic [1:0] {KIgn, KOn, KOff, KClr} kind_t;

    state_t          r_state;
    kind_t           r_kind;
    kind_t           w_kind;
    logic [7:0]      r_status;
    logic [6:0]      r_note_in;
    logic [6:0]      r_vel_in;
    logic            r_hit;
    logic [IW-1:0]   r_idx;
    logic [6:0]      r_notes [DEPTH];
    logic [6:0]      r_vels  [DEPTH];
    logic [CW-1:0]   r_count;
    logic [6:0]      r_note;
    logic [6:0]      r_vel;
    logic            r_gate;
    logic            r_changed;
    logic            r_busy;
    logic [7:0]      r_drop;

    logic            w_ch_ok;
    logic            w_hit;
    logic [IW-1:0]   w_idx;
    logic [6:0]      w_notes_nx [DEPTH];
    logic [6:0]      w_vels_nx  [DEPTH];
    logic [CW-1:0]   w_count_nx;
    logic            w_gate_nx;
    logic [6:0]      w_note_nx;
    logic [6:0]      w_vel_nx;
    logic            w_chg;

    always_comb begin
        w_ch_ok = (OMNI != 0) || (r_status[3:0] == 4'(CHANNEL));
        w_kind  = KIgn;
        if (w_ch_ok) begin
            case (r_status[7:4])
                4'h9:    w_kind = (r_vel_in != 7'd0) ? KOn : KOff;
                4'h8:    w_kind = KOff;
                4'hB:    w_kind = (r_note_in == 7'd123 || r_note_in == 7'd120) ? KClr : KIgn;
                default: w_kind = KIgn;
            endcase
        end
    end

    // Descending scan so the lowest matching index wins.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (CW'(j) < r_count && r_notes[j] == r_note_in) begin
                w_hit = 1'b1;
                w_idx = IW'(j);
            end
        end
    end

    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            w_notes_nx[j] = r_notes[j];
            w_vels_nx[j]  = r_vels[j];
        end
        w_count_nx = r_count;
        case (r_kind)
            KOn: begin
                w_notes_nx[0] = r_note_in;
                w_vels_nx[0]  = r_vel_in;
                for (int j = 1; j < DEPTH; j++) begin
                    if (!r_hit || IW'(j) <= r_idx) begin
                        w_notes_nx[j] = r_notes[j-1];
                        w_vels_nx[j]  = r_vels[j-1];
                    end
                end
                if (!r_hit && r_count != DEPTH_C) w_count_nx = r_count + 1'b1;
            end
            KOff: begin
                if (r_hit) begin
                    for (int j = 0; j < DEPTH - 1; j++) begin
                        if (IW'(j) >= r_idx) begin
                            w_notes_nx[j] = r_notes[j+1];
                            w_vels_nx[j]  = r_vels[j+1];
                        end
                    end
                    w_count_nx = r_count - 1'b1;
                end
            end
            KClr:    w_count_nx = '0;
            default: ;
        endcase
        // With an empty stack the last note/velocity are held for the envelope tail.
        w_gate_nx = (w_count_nx != '0);
        w_note_nx = w_gate_nx ? w_notes_nx[0] : r_note;
        w_vel_nx  = w_gate_nx ? w_vels_nx[0]  : r_vel;
        w_chg     = (w_gate_nx != r_gate) || (w_note_nx != r_note) || (w_vel_nx != r_vel);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state   <= StIdle;
            r_kind    <= KIgn;
            r_status  <= '0;
            r_note_in <= '0;
            r_vel_in  <= '0;
            r_hit     <= 1'b0;
            r_idx     <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                r_notes[j] <= '0;
                r_vels[j]  <= '0;
            end
            r_count   <= '0;
            r_note    <= '0;
            r_vel     <= '0;
            r_gate    <= 1'b0;
            r_changed <= 1'b0;
            r_busy    <= 1'b0;
            r_drop    <= '0;
        end else begin
            if (valid_in && r_state != StIdle && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
            case (r_state)
                StIdle: begin
                    if (valid_in) begin
                        r_status  <= midi_event_in[23:16];
                        r_note_in <= midi_event_in[14:8];
                        r_vel_in  <= midi_event_in[6:0];
                        r_busy    <= 1'b1;
                        r_state   <= StLatch;
                    end
                end
                StLatch: begin
                    r_kind  <= w_kind;
                    r_state <= StMatch;
                end
                StMatch: begin
                    r_hit   <= w_hit;
                    r_idx   <= w_idx;
                    r_state <= StUpdate;
                end
                StUpdate: begin
                    for (int j = 0; j < DEPTH; j++) begin
                        r_notes[j] <= w_notes_nx[j];
                        r_vels[j]  <= w_vels_nx[j];
                    end
                    r_count   <= w_count_nx;
                    r_note    <= w_note_nx;
                    r_vel     <= w_vel_nx;
                    r_gate    <= w_gate_nx;
                    r_changed <= w_chg;
                    r_state   <= StOutput;
                end
                StOutput: begin
                    r_changed <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign note_out       = r_note;
    assign velocity_out   = r_vel;
    assign gate_out       = r_gate;
    assign changed_out    = r_changed;
    assign count_out      = r_count;
    assign busy_out       = r_busy;
    assign drop_count_out = r_drop;

endmodule
